// File: rtl/magnetron_pkg.sv
// Shared state encoding and power-level helper for the magnetron controller.
package magnetron_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        SET   = 3'd1,
        COOK  = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    // A zero or out-of-range request means full power.
    function automatic int unsigned sat_power(input int unsigned p, input int unsigned period);
        return ((p == 0) || (p > period)) ? period : p;
    endfunction

endpackage

// File: rtl/magnetron_pwm.sv
// Power-level duty-cycle window: free-running window counter compared against the power level.
module magnetron_pwm #(
    parameter int unsigned PWR_PERIOD = 10,
    parameter int unsigned PWR_W      = $clog2(PWR_PERIOD + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [PWR_W-1:0] power,
    output logic             pwm_on
);

    logic [PWR_W-1:0] pwm_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pwm_cnt <= '0;
        end else if (en) begin
            pwm_cnt <= (pwm_cnt == PWR_W'(PWR_PERIOD - 1)) ? '0 : pwm_cnt + PWR_W'(1);
        end
    end

    assign pwm_on = (pwm_cnt < power);

endmodule

// File: rtl/magnetron_ctrl.sv
// Magnetron controller: cook-time countdown, power window, pause/resume, done reporting.
// Optional end-of-cook beep enabled by defining MAGNETRON_BEEP_EN.
module magnetron_ctrl
    import magnetron_pkg::*;
#(
    parameter int unsigned TIME_W     = 8,
    parameter int unsigned TICK_DIV   = 4,
    parameter int unsigned PWR_PERIOD = 10,
    parameter int unsigned PWR_W      = $clog2(PWR_PERIOD + 1),
    parameter int unsigned BEEP_LEN   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               startn,
    input  logic               stopn,
    input  logic               clearn,
    input  logic               door_closed,
    input  logic               load,
    input  logic [TIME_W-1:0]  time_in,
    input  logic [PWR_W-1:0]   power_in,
    output logic               mag_on,
    output logic [TIME_W-1:0]  time_left,
    output logic [STATE_W-1:0] state_o,
    output logic               done,
    output logic               beep
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t             state;
    logic [PWR_W-1:0]   power_q;
    logic [TICK_W-1:0]  tick_cnt;
    logic               pwm_on;
    logic               cook_run;
    logic               cook_finish;
    logic               load_ok;
    logic               start_ok;
    logic               pwm_clr;

    // Stop/door-open outrank the tick, so the countdown only advances while cooking uninterrupted.
    assign cook_run    = (state == COOK) && door_closed && stopn;
    assign cook_finish = cook_run && (tick_cnt == TICK_W'(TICK_DIV - 1)) && (time_left == TIME_W'(1));
    assign load_ok     = load && ((state == IDLE) || (state == SET) || ((state == DONE) && door_closed));
    assign start_ok    = !startn && door_closed && stopn && (time_left != '0) &&
                         (((state == SET) && !load) || (state == PAUSE));
    assign pwm_clr     = !clearn || start_ok;

    always_ff @(posedge clk) begin
        if (rst || !clearn) begin
            state     <= IDLE;
            time_left <= '0;
            power_q   <= PWR_W'(PWR_PERIOD);
            tick_cnt  <= '0;
        end else if (state == COOK) begin
            if (!cook_run) begin
                state <= PAUSE;
            end else if (tick_cnt == TICK_W'(TICK_DIV - 1)) begin
                tick_cnt <= '0;
                if (time_left == TIME_W'(1)) begin
                    time_left <= '0;
                    state     <= DONE;
                end else begin
                    time_left <= time_left - TIME_W'(1);
                end
            end else begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end
        end else if ((state == DONE) && !door_closed) begin
            state <= IDLE;
        end else if (load_ok) begin
            time_left <= time_in;
            state     <= (time_in != '0) ? SET : IDLE;
            power_q   <= PWR_W'(sat_power(32'(power_in), PWR_PERIOD));
        end else if (start_ok) begin
            state    <= COOK;
            tick_cnt <= '0;
        end
    end

    magnetron_pwm #(
        .PWR_PERIOD (PWR_PERIOD),
        .PWR_W      (PWR_W)
    ) u_pwm (
        .clk    (clk),
        .rst    (rst),
        .clr    (pwm_clr),
        .en     (cook_run),
        .power  (power_q),
        .pwm_on (pwm_on)
    );

    // Door gating stays combinational so opening the door cuts power within the same cycle.
    assign mag_on  = (state == COOK) && door_closed && pwm_on;
    assign state_o = state;
    assign done    = (state == DONE);

`ifdef MAGNETRON_BEEP_EN
    localparam int unsigned BEEP_W = $clog2(BEEP_LEN + 1);

    logic [BEEP_W-1:0] beep_cnt;

    always_ff @(posedge clk) begin
        if (rst || !clearn) begin
            beep_cnt <= '0;
        end else if (cook_finish) begin
            beep_cnt <= BEEP_W'(BEEP_LEN);
        end else if (beep_cnt != '0) begin
            beep_cnt <= beep_cnt - BEEP_W'(1);
        end
    end

    assign beep = (beep_cnt != '0);
`else
    assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_magnetron_ctrl.sv
// Self-checking bench for magnetron_ctrl: directed scenarios then randomized traffic vs. a behavioural model.
module tb_magnetron_ctrl;

    localparam int unsigned TIME_W     = 8;
    localparam int unsigned TICK_DIV   = 4;
    localparam int unsigned PWR_PERIOD = 10;
    localparam int unsigned PWR_W      = $clog2(PWR_PERIOD + 1);
    localparam int unsigned BEEP_LEN   = 8;

    localparam int S_IDLE  = 0;
    localparam int S_SET   = 1;
    localparam int S_COOK  = 2;
    localparam int S_PAUSE = 3;
    localparam int S_DONE  = 4;

    logic              clk = 1'b0;
    logic              rst, startn, stopn, clearn, door_closed, load;
    logic [TIME_W-1:0] time_in;
    logic [PWR_W-1:0]  power_in;
    logic              mag_on, done, beep;
    logic [TIME_W-1:0] time_left;
    logic [2:0]        state_o;

    magnetron_ctrl #(
        .TIME_W     (TIME_W),
        .TICK_DIV   (TICK_DIV),
        .PWR_PERIOD (PWR_PERIOD),
        .BEEP_LEN   (BEEP_LEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .startn      (startn),
        .stopn       (stopn),
        .clearn      (clearn),
        .door_closed (door_closed),
        .load        (load),
        .time_in     (time_in),
        .power_in    (power_in),
        .mag_on      (mag_on),
        .time_left   (time_left),
        .state_o     (state_o),
        .done        (done),
        .beep        (beep)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    bit          armed = 1'b0;

    int m_state = S_IDLE;
    int m_time  = 0;
    int m_power = PWR_PERIOD;
    int m_tick  = 0;
    int m_pwm   = 0;
    int m_beep  = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int exp_mag;
        int exp_beep;
        exp_mag = (m_state == S_COOK && door_closed && m_pwm < m_power) ? 1 : 0;
`ifdef MAGNETRON_BEEP_EN
        exp_beep = (m_beep > 0) ? 1 : 0;
`else
        exp_beep = 0;
`endif
        if (armed) begin
            check("state_o",   state_o,   m_state);
            check("time_left", time_left, m_time);
            check("mag_on",    mag_on,    exp_mag);
            check("done",      done,      (m_state == S_DONE) ? 1 : 0);
            check("beep",      beep,      exp_beep);
        end
    endtask

    task automatic model_step();
        int p;
        if (m_beep > 0) m_beep--;
        if (rst || !clearn) begin
            m_state = S_IDLE; m_time = 0; m_power = PWR_PERIOD;
            m_tick = 0; m_pwm = 0; m_beep = 0;
        end else if (m_state == S_COOK) begin
            if (!stopn || !door_closed) begin
                m_state = S_PAUSE;
            end else begin
                m_pwm = (m_pwm + 1) % PWR_PERIOD;
                m_tick++;
                if (m_tick == TICK_DIV) begin
                    m_tick = 0;
                    m_time--;
                    if (m_time == 0) begin
                        m_state = S_DONE;
                        m_beep  = BEEP_LEN;
                    end
                end
            end
        end else if (m_state == S_DONE && !door_closed) begin
            m_state = S_IDLE;
        end else if (load && m_state != S_PAUSE) begin
            p       = int'(power_in);
            m_time  = int'(time_in);
            m_state = (m_time != 0) ? S_SET : S_IDLE;
            m_power = (p == 0 || p > PWR_PERIOD) ? PWR_PERIOD : p;
        end else if (!startn && door_closed && stopn && m_time != 0 &&
                     (m_state == S_SET || m_state == S_PAUSE)) begin
            m_state = S_COOK; m_tick = 0; m_pwm = 0;
        end
    endtask

    // Entered and left at a falling edge; inputs are set by the caller beforehand.
    task automatic run(input int n);
        repeat (n) begin
            #1 check_outputs();
            @(posedge clk);
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic do_load(input int t, input int p);
        load = 1'b1; time_in = TIME_W'(t); power_in = PWR_W'(p);
        run(1);
        load = 1'b0;
    endtask

    task automatic do_start();
        startn = 1'b0; run(1); startn = 1'b1;
    endtask

    initial begin
        rst = 1'b1; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
        door_closed = 1'b1; load = 1'b0; time_in = '0; power_in = '0;
        @(negedge clk);
        run(1);
        armed = 1'b1;
        run(1);
        rst = 1'b0;
        run(1);

        // Full-power cook, 3 s
        do_load(3, 10); do_start(); run(16);
        // 30 % power window, then saturation of 0 and 15
        do_load(2, 3);  do_start(); run(10);
        do_load(2, 0);  do_start(); run(9);
        do_load(2, 15); do_start(); run(9);
        // Door opened at time_left=2, then resumed
        do_load(3, 10); do_start(); run(4);
        door_closed = 1'b0; run(3);
        door_closed = 1'b1; run(2);
        do_start(); run(10);
        // Stop button pause, load ignored while cooking
        do_load(3, 5); do_start(); run(2);
        stopn = 1'b0; run(3); stopn = 1'b1;
        do_start(); run(2);
        do_load(9, 2); run(2);
        // Clear together with start, then start with no time loaded
        clearn = 1'b0; startn = 1'b0; run(1);
        clearn = 1'b1; run(2); startn = 1'b1;
        // Reset in the middle of a cook
        do_load(3, 7); do_start(); run(5);
        rst = 1'b1; run(1); rst = 1'b0; run(2);
        // Door opened in DONE returns to IDLE
        do_load(1, 10); do_start(); run(5);
        door_closed = 1'b0; run(2); door_closed = 1'b1; run(1);

        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom_range(0, 299) == 0);
            clearn   = ($urandom_range(0, 79) != 0);
            startn   = ($urandom_range(0, 5) != 0);
            stopn    = ($urandom_range(0, 39) != 0);
            load     = ($urandom_range(0, 15) == 0);
            time_in  = TIME_W'($urandom_range(0, 5));
            power_in = PWR_W'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) door_closed = ~door_closed;
            run(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
